cr_prefix_attach_pti_mc: RTL

CR_PREFIX_ATTACH_PTI_MC -- requirements
Module: cr_prefix_attach_pti_mc

---
 rtl/cr_prefix_attach_pti_mc.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cr_prefix_attach_pti_mc.sv
`default_nettype none
// ============================================================================
// Module   : cr_prefix_attach_pti_mc
// Brief    : Multi-channel TLV prefix insertion engine. Round-robin grants one
//            requesting channel at a time and emits header, payload and CRC
//            words through a single registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module cr_prefix_attach_pti_mc #(
   parameter int N_CH = 2,
   parameter int DW   = 64,
   parameter int MAXW = 255,
   localparam int SW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bypass,
   input  logic                hdr_capture,
   input  logic [DW-1:0]       hdr_word,
   input  logic [N_CH-1:0]     req,
   input  logic [N_CH*8-1:0]   ch_type,
   input  logic [N_CH*8-1:0]   ch_nwords,
   input  logic [N_CH*32-1:0]  ch_crc,
   input  logic [DW-1:0]       src_data,
   input  logic [N_CH-1:0]     src_valid,
   output logic [N_CH-1:0]     src_pop,
   output logic [SW-1:0]       src_ch,
   output logic [N_CH-1:0]     inwrk,
   output logic [N_CH-1:0]     ack,
   output logic                ob_valid,
   input  logic                ob_ready,
   output logic [DW-1:0]       ob_data,
   output logic                ob_sot,
   output logic                ob_eot,
   output logic                ob_insert,
   output logic [7:0]          ob_tuser,
   output logic [7:0]          ob_type
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_CRC  = 3'd3,
      ST_ACK  = 3'd4
   } state_t;

   localparam logic [7:0] C_MAXW = (MAXW > 255) ? 8'hFF : 8'(MAXW);

   // per-channel views of the packed configuration buses
   logic [7:0]  type_a [N_CH];
   logic [7:0]  nw_a   [N_CH];
   logic [31:0] crc_a  [N_CH];

   for (genvar c = 0; c < N_CH; c++) begin : g_unpack
      assign type_a[c] = ch_type[c*8 +: 8];
      assign nw_a[c]   = ch_nwords[c*8 +: 8];
      assign crc_a[c]  = ch_crc[c*32 +: 32];
   end

   // the low header bits are replaced by length/type, never forwarded
   logic unused_hdr_lo;
   assign unused_hdr_lo = ^hdr_word[23:0];

   state_t          state_q, state_d;
   logic [SW-1:0]   g_q, g_d;          // granted channel
   logic [SW-1:0]   ptr_q, ptr_d;      // round-robin search start
   logic [7:0]      nw_q, nw_d;        // payload length latched at grant
   logic [7:0]      cnt_q, cnt_d;      // payload words popped so far
   logic [N_CH-1:0] done_q, done_d;
   logic [DW-25:0]  hdr_q, hdr_d;      // captured frame word 0, upper bits
   logic            ov_q, ov_d;        // output register
   logic [DW-1:0]   od_q, od_d;
   logic            osot_q, osot_d;
   logic            oeot_q, oeot_d;
   logic [7:0]      otu_q, otu_d;
   logic [7:0]      oty_q, oty_d;

   logic [N_CH-1:0] elig;
   logic [SW:0]     pick;
   logic [SW-1:0]   gi;
   logic [7:0]      nw_sat;
   logic            can_load;
   logic [N_CH-1:0] onehot_g;

   // Lowest rotated distance from the search start wins; constant indices only.
   function automatic logic [SW:0] rr_pick(input logic [N_CH-1:0] e,
                                           input logic [SW-1:0]   start);
      logic [SW:0] r;
      int          best;
      int          d;
      r    = '0;
      best = N_CH;
      for (int i = 0; i < N_CH; i++) begin
         if (e[i]) begin
            d = i - int'(start);
            if (d < 0) d = d + N_CH;
            if (d < best) begin
               best = d;
               r    = {1'b1, SW'(i)};
            end
         end
      end
      return r;
   endfunction

   // state register and datapath flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         nw_q    <= '0;
         cnt_q   <= '0;
         done_q  <= '0;
         hdr_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         osot_q  <= 1'b0;
         oeot_q  <= 1'b0;
         otu_q   <= '0;
         oty_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         nw_q    <= nw_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         hdr_q   <= hdr_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         osot_q  <= osot_d;
         oeot_q  <= oeot_d;
         otu_q   <= otu_d;
         oty_q   <= oty_d;
      end
   end

   // arbitration, next-state and output-register load logic
   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      ptr_d    = ptr_q;
      nw_d     = nw_q;
      cnt_d    = cnt_q;
      done_d   = done_q & req;
      hdr_d    = hdr_capture ? hdr_word[DW-1:24] : hdr_q;
      can_load = ~ov_q | ob_ready;
      ov_d     = ov_q & ~ob_ready;
      od_d     = od_q;
      osot_d   = osot_q;
      oeot_d   = oeot_q;
      otu_d    = otu_q;
      oty_d    = oty_q;
      src_pop  = '0;

      elig   = req & ~done_q & ~{N_CH{bypass}};
      pick   = rr_pick(elig, ptr_q);
      gi     = pick[SW-1:0];
      nw_sat = (nw_a[gi] > C_MAXW) ? C_MAXW : nw_a[gi];

      case (state_q)
         ST_IDLE: begin
            // output stage is always empty here, so the header loads at grant
            if (pick[SW]) begin
               g_d     = gi;
               ptr_d   = SW'((int'(gi) + 1) % N_CH);
               nw_d    = nw_sat;
               cnt_d   = '0;
               ov_d    = 1'b1;
               od_d    = {hdr_q, 7'd0, nw_sat, 1'b0, type_a[gi]};
               osot_d  = 1'b1;
               oeot_d  = 1'b0;
               otu_d   = 8'd1;
               oty_d   = type_a[gi];
               state_d = ST_HDR;
            end
         end
         ST_HDR, ST_DATA: begin
            // header acceptance doubles as the first payload slot: no bubble
            if (can_load) begin
               state_d = ST_DATA;
               if (cnt_q == nw_q) begin
                  ov_d    = 1'b1;
                  od_d    = {32'd0, crc_a[g_q]};
                  osot_d  = 1'b0;
                  oeot_d  = 1'b1;
                  otu_d   = 8'd2;
                  oty_d   = type_a[g_q];
                  state_d = ST_CRC;
               end else if (src_valid[g_q]) begin
                  src_pop[g_q] = 1'b1;
                  cnt_d        = cnt_q + 8'd1;
                  ov_d         = 1'b1;
                  od_d         = src_data;
                  osot_d       = 1'b0;
                  oeot_d       = 1'b0;
                  otu_d        = 8'd0;
                  oty_d        = type_a[g_q];
               end
            end
         end
         ST_CRC: begin
            if (ob_ready) state_d = ST_ACK;
         end
         ST_ACK: begin
            // a channel whose req already dropped stays re-grantable
            if (req[g_q]) done_d[g_q] = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign onehot_g  = N_CH'(1) << g_q;
   assign src_ch    = g_q;
   assign inwrk     = (state_q == ST_HDR || state_q == ST_DATA || state_q == ST_CRC)
                      ? onehot_g : '0;
   assign ack       = (state_q == ST_ACK) ? onehot_g : '0;
   assign ob_valid  = ov_q;
   assign ob_data   = ov_q ? od_q : '0;
   assign ob_sot    = ov_q & osot_q;
   assign ob_eot    = ov_q & oeot_q;
   assign ob_insert = ov_q;
   assign ob_tuser  = ov_q ? otu_q : '0;
   assign ob_type   = ov_q ? oty_q : '0;

endmodule
`default_nettype wire
